// File: rtl/tlul_rsp_intg_gen_fifo.sv
// TL-UL device-response integrity generator with a small response buffer.
// Each accepted D-channel response gets its response and data integrity
// bits computed at push time. The stamped word is held in a FIFO of Depth
// entries and presented to the host with valid/ready handshaking.

package tlul_rsp_intg_pkg;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic       d_valid;
        tl_d_op_e   d_opcode;
        logic [2:0] d_param;
        logic [1:0] d_size;
        logic [7:0] d_source;
        logic       d_sink;
        logic [31:0] d_data;
        tl_d_user_t d_user;
        logic       d_error;
        logic       a_ready;
    } tl_d2h_t;

endpackage

module tlul_rsp_intg_gen_fifo
    import tlul_rsp_intg_pkg::*;
#(
    parameter int unsigned Depth          = 2,
    parameter bit          EnableRspIntg  = 1'b1,
    parameter bit          EnableDataIntg = 1'b1,
    localparam int unsigned CntW          = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_d2h_t         tl_i,
    output logic            tl_i_ready_o,
    output tl_d2h_t         tl_o,
    input  logic            tl_o_ready_i,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    // Hsiao SECDED(64,57) parity masks for the response header.
    localparam logic [63:0] RspMask [7] = '{
        64'h0103FFF800007FFF, 64'h017C1FF801FF801F, 64'h01BDE1F87E0781E1,
        64'h01DEEE3B8E388E22, 64'h01EF76CDB2C93244, 64'h01F7BB56D5525488,
        64'h01FBDDA769A46910
    };

    // Hsiao SECDED(39,32) parity masks for the data word.
    localparam logic [38:0] DataMask [7] = '{
        39'h002606BD25, 39'h00DEBA8050, 39'h00413D89AA, 39'h0031234ED1,
        39'h00C2C1323B, 39'h002DCC624C, 39'h0098505586
    };

    tl_d2h_t         mem_reg [Depth];
    logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntW-1:0] count_reg, count_next;

    logic [63:0] rsp_payload;
    logic [38:0] data_payload;
    logic [6:0]  rsp_calc;
    logic [6:0]  data_calc;
    tl_d2h_t     push_entry;
    logic        push;
    logic        pop;

    // Header payload is {opcode, size, error}, error at bit 0, zero-extended.
    assign rsp_payload  = 64'({tl_i.d_opcode, tl_i.d_size, tl_i.d_error});
    assign data_payload = 39'(tl_i.d_data);

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_parity
            assign rsp_calc[gi]  = ^(rsp_payload & RspMask[gi]);
            assign data_calc[gi] = ^(data_payload & DataMask[gi]);
        end
    endgenerate

    // Acceptance depends only on occupancy, never on the host's ready.
    assign tl_i_ready_o = (count_reg < FullCnt);
    assign push         = tl_i.d_valid && tl_i_ready_o;
    assign pop          = (count_reg != '0) && tl_o_ready_i;
    assign count_o      = count_reg;

    // Build the stored word: handshake bits cleared, integrity stamped or passed.
    always_comb begin
        push_entry                  = tl_i;
        push_entry.d_valid          = 1'b0;
        push_entry.a_ready          = 1'b0;
        push_entry.d_user.rsp_intg  = EnableRspIntg  ? rsp_calc  : tl_i.d_user.rsp_intg;
        push_entry.d_user.data_intg = EnableDataIntg ? data_calc : tl_i.d_user.data_intg;
    end

    // Pointer and occupancy update; pointers wrap at Depth, not a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
            // Each slot captures the stamped word when the write pointer selects it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PtrW'(gi))) begin
                    mem_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    // Present the head entry; everything but a_ready is zero while empty.
    always_comb begin
        tl_o = '0;
        if (count_reg != '0) begin
            tl_o         = mem_reg[rd_ptr_reg];
            tl_o.d_valid = 1'b1;
        end
        tl_o.a_ready = tl_i.a_ready;
    end

endmodule

// File: tb/tb_tlul_rsp_intg_gen_fifo.sv
// Bench for tlul_rsp_intg_gen_fifo: one instance with Depth 2 and integrity
// generation, one with Depth 3 in pass-through mode, both fed the same
// responses and compared each cycle against queue-based reference models.

module tb_tlul_rsp_intg_gen_fifo;
    import tlul_rsp_intg_pkg::*;

    localparam logic [63:0] M [7] = '{
        64'h0103FFF800007FFF, 64'h017C1FF801FF801F, 64'h01BDE1F87E0781E1,
        64'h01DEEE3B8E388E22, 64'h01EF76CDB2C93244, 64'h01F7BB56D5525488,
        64'h01FBDDA769A46910
    };
    localparam logic [38:0] N [7] = '{
        39'h002606BD25, 39'h00DEBA8050, 39'h00413D89AA, 39'h0031234ED1,
        39'h00C2C1323B, 39'h002DCC624C, 39'h0098505586
    };

    logic       clk = 1'b0;
    logic       rst_n;
    tl_d2h_t    tl_in;
    logic       rdy_a, rdy_b;
    logic       ready_a, ready_b;
    tl_d2h_t    out_a, out_b;
    logic [1:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    tl_d2h_t qa[$];
    tl_d2h_t qb[$];

    always #5 clk = ~clk;

    tlul_rsp_intg_gen_fifo #(
        .Depth(2), .EnableRspIntg(1'b1), .EnableDataIntg(1'b1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_in), .tl_i_ready_o(ready_a),
        .tl_o(out_a), .tl_o_ready_i(rdy_a), .count_o(cnt_a)
    );

    tlul_rsp_intg_gen_fifo #(
        .Depth(3), .EnableRspIntg(1'b0), .EnableDataIntg(1'b0)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_in), .tl_i_ready_o(ready_b),
        .tl_o(out_b), .tl_o_ready_i(rdy_b), .count_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference stamping: parity of the masked payload, counted with $countones.
    function automatic tl_d2h_t stamp_gen(input tl_d2h_t t);
        tl_d2h_t     r;
        logic [63:0] p;
        logic [38:0] d;
        r = t;
        r.d_valid = 1'b0;
        r.a_ready = 1'b0;
        p = '0;
        p[5:0] = {t.d_opcode, t.d_size, t.d_error};
        d = {7'd0, t.d_data};
        for (int i = 0; i < 7; i++) begin
            r.d_user.rsp_intg[i]  = 1'($countones(p & M[i]) % 2);
            r.d_user.data_intg[i] = 1'($countones(d & N[i]) % 2);
        end
        return r;
    endfunction

    function automatic tl_d2h_t stamp_pass(input tl_d2h_t t);
        tl_d2h_t r;
        r = t;
        r.d_valid = 1'b0;
        r.a_ready = 1'b0;
        return r;
    endfunction

    function automatic tl_d2h_t exp_out(input tl_d2h_t head, input bit nonempty, input logic ar);
        tl_d2h_t r;
        r = nonempty ? head : '0;
        r.d_valid = nonempty;
        r.a_ready = ar;
        return r;
    endfunction

    task automatic check_all();
        tl_d2h_t ha, hb;
        ha = (qa.size() > 0) ? qa[0] : '0;
        hb = (qb.size() > 0) ? qb[0] : '0;
        chk("ready_a", ready_a, qa.size() < 2);
        chk("count_a", cnt_a, qa.size());
        chk("tl_o_a", out_a, exp_out(ha, qa.size() > 0, tl_in.a_ready));
        chk("ready_b", ready_b, qb.size() < 3);
        chk("count_b", cnt_b, qb.size());
        chk("tl_o_b", out_b, exp_out(hb, qb.size() > 0, tl_in.a_ready));
    endtask

    // One clock: check the settled outputs, then advance models at the edge.
    task automatic cycle();
        bit push_a, pop_a, push_b, pop_b;
        #1;
        check_all();
        push_a = tl_in.d_valid && (qa.size() < 2);
        pop_a  = (qa.size() > 0) && rdy_a;
        push_b = tl_in.d_valid && (qb.size() < 3);
        pop_b  = (qb.size() > 0) && rdy_b;
        @(posedge clk);
        if (pop_a)  void'(qa.pop_front());
        if (push_a) qa.push_back(stamp_gen(tl_in));
        if (pop_b)  void'(qb.pop_front());
        if (push_b) qb.push_back(stamp_pass(tl_in));
        @(negedge clk);
    endtask

    task automatic set_rsp(input tl_d_op_e op, input logic [1:0] sz, input logic err,
                           input logic [31:0] data, input logic [13:0] user);
        tl_in          = '0;
        tl_in.d_valid  = 1'b1;
        tl_in.d_opcode = op;
        tl_in.d_size   = sz;
        tl_in.d_error  = err;
        tl_in.d_data   = data;
        tl_in.d_user   = user;
    endtask

    task automatic randomize_input();
        tl_in.d_valid  = 1'($urandom_range(0, 3) != 0);
        tl_in.d_opcode = tl_d_op_e'(3'($urandom_range(0, 1)));
        tl_in.d_param  = 3'($urandom);
        tl_in.d_size   = 2'($urandom);
        tl_in.d_source = 8'($urandom);
        tl_in.d_sink   = 1'($urandom);
        tl_in.d_data   = $urandom;
        tl_in.d_user   = 14'($urandom);
        tl_in.d_error  = 1'($urandom);
        tl_in.a_ready  = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        tl_in = '0;
        rdy_a = 1'b0;
        rdy_b = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_all();
        chk("rst_ready_a", ready_a, 1'b1);
        chk("rst_valid_a", out_a.d_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero response; user bits must be overwritten on A and kept on B.
        set_rsp(AccessAck, 2'd0, 1'b0, 32'h0, 14'h2AAA);
        cycle();
        tl_in.d_valid = 1'b0;
        chk("zero_valid", out_a.d_valid, 1'b1);
        chk("zero_rsp_intg", out_a.d_user.rsp_intg, 7'h00);
        chk("zero_data_intg", out_a.d_user.data_intg, 7'h00);
        chk("zero_count", cnt_a, 2'd1);
        chk("pass_user", out_b.d_user, 14'h2AAA);

        // Known vectors, each pushed while the previous one pops (count stays 1).
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        set_rsp(AccessAckData, 2'd2, 1'b0, 32'h1, 14'h0);
        cycle();
        chk("kv1_count", cnt_a, 2'd1);
        chk("kv1_rsp_intg", out_a.d_user.rsp_intg, 7'h30);
        chk("kv1_data_intg", out_a.d_user.data_intg, 7'h19);
        set_rsp(AccessAck, 2'd0, 1'b1, 32'h0, 14'h0);
        cycle();
        chk("kv2_count", cnt_a, 2'd1);
        chk("kv2_rsp_intg", out_a.d_user.rsp_intg, 7'h07);
        tl_in.d_valid = 1'b0;
        cycle();
        chk("drain_valid", out_a.d_valid, 1'b0);

        // Back-pressure on A: the third push waits until a slot frees.
        rdy_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_rsp(AccessAckData, 2'd2, 1'b0, 32'hA0 + k, 14'h0);
            cycle();
        end
        chk("bp_ready", ready_a, 1'b0);
        chk("bp_count", cnt_a, 2'd2);
        chk("bp_head", out_a.d_data, 32'hA0);
        rdy_a = 1'b1;
        cycle();
        cycle();
        tl_in.d_valid = 1'b0;
        repeat (3) cycle();

        // Back-to-back pushes into the Depth-3 instance to wrap its pointers.
        for (int k = 0; k < 10; k++) begin
            set_rsp(AccessAckData, 2'd2, 1'b0, 32'hB00 + k, 14'(k));
            rdy_a = 1'b1;
            rdy_b = (k >= 2);
            cycle();
        end
        tl_in.d_valid = 1'b0;
        rdy_b = 1'b1;
        repeat (4) cycle();

        // Asynchronous reset with two entries buffered.
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_rsp(AccessAckData, 2'd1, 1'b0, 32'hC0 + k, 14'h0);
            cycle();
        end
        tl_in.d_valid = 1'b0;
        chk("pre_rst_count", cnt_a, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_a", out_a.d_valid, 1'b0);
        chk("mid_rst_count_a", cnt_a, 2'd0);
        chk("mid_rst_count_b", cnt_b, 2'd0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        set_rsp(AccessAckData, 2'd2, 1'b0, 32'hD00D, 14'h0);
        cycle();
        tl_in.d_valid = 1'b0;
        chk("post_rst_data", out_a.d_data, 32'hD00D);
        chk("post_rst_count", cnt_a, 2'd1);

        // Randomised traffic against the queue models.
        for (int k = 0; k < 400; k++) begin
            randomize_input();
            rdy_a = 1'($urandom_range(0, 2) != 0);
            rdy_b = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        tl_in.d_valid = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        repeat (5) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlul_rsp_intg_gen_fifo.md
# tlul_rsp_intg_gen_fifo

Registered TL-UL device-response integrity generator with a parametrised response buffer. It sits between a device's raw D-channel response and the bus. For each buffered response it stamps `d_user.rsp_intg`, computed with the Hsiao SECDED(64,57) code over `{d_opcode, d_size, d_error}`. When enabled, it also stamps `d_user.data_intg`, computed with SECDED(39,32) over `d_data`. It is the sequential successor to the combinational response-integrity path: encoding is registered, and responses are decoupled from the host by a valid/ready FIFO of `Depth` entries.

## Interface
- `Depth`, 2: number of buffered responses; legal range 1..4.
- `EnableRspIntg`, 1: 1 = generate `rsp_intg`; 0 = pass `tl_i.d_user.rsp_intg` through unchanged.
- `EnableDataIntg`, 1: 1 = generate `data_intg`; 0 = pass `tl_i.d_user.data_intg` through unchanged.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `tl_i`  in  tl_d2h_t  raw response. `d_valid` is the push request; `a_ready` is passed through.
- `tl_i_ready_o`  out  1  push accepted this cycle when `tl_i.d_valid` is high.
- `tl_o`  out  tl_d2h_t  stamped response. `d_valid` is high when the buffer is not empty.
- `tl_o_ready_i`  in  1  host accepts the head entry.
- `count_o`  out  $clog2(Depth+1)  number of occupied entries.

## Operation
**Push**
- Push occurs when `tl_i.d_valid && tl_i_ready_o`.
- `tl_i_ready_o = (count < Depth)`. It is combinational from state only and never depends on `tl_o_ready_i`.
- Encoding is computed combinationally from `tl_i` and stored with the entry. The stored word holds all `tl_d2h_t` fields except `d_valid` and `a_ready`.

**Response integrity**
- Payload is `p = 57'({d_opcode, d_size, d_error})`, zero-extended, with `d_error` at bit 0.
- `rsp_intg[i] = ^(64'(p) & M[i])`, where M[0..6] = 64'h0103FFF800007FFF, 64'h017C1FF801FF801F, 64'h01BDE1F87E0781E1, 64'h01DEEE3B8E388E22, 64'h01EF76CDB2C93244, 64'h01F7BB56D5525488, 64'h01FBDDA769A46910.

**Data integrity**
- `data_intg[i] = ^(39'(d_data) & N[i])`, where N[0..6] = 39'h002606BD25, 39'h00DEBA8050, 39'h00413D89AA, 39'h0031234ED1, 39'h00C2C1323B, 39'h002DCC624C, 39'h0098505586.
- Integrity is computed on every push, including pushes with `d_error = 1`.

**Pop and ordering**
- Pop occurs when `tl_o.d_valid && tl_o_ready_i`.
- `tl_o` shows the head entry, with `d_valid = (count != 0)`. `tl_o.a_ready = tl_i.a_ready`, combinationally.
- When empty, all `tl_o` fields except `a_ready` are driven to 0.
- Order is strict FIFO. Read and write pointers wrap modulo `Depth`, for any `Depth` including non-powers-of-two.

**Simultaneous events**
- Push and pop in the same cycle with 0 < count < Depth: count is unchanged and both pointers advance.
- When full, no push is possible in that cycle, even if a pop occurs. There is no pass-through.
- When empty, a push is not visible at `tl_o` until the next cycle.

## Timing
- Reset (asynchronous assert): count = 0, pointers = 0, `tl_o.d_valid` = 0, all stored entries = 0, `tl_i_ready_o` = 1, `count_o` = 0.
- Reset mid-operation discards all buffered entries immediately, without waiting for a clock edge.
- Latency from push edge to `tl_o.d_valid` is 1 cycle.
- `Depth = 1` sustains one response every 2 cycles; `Depth >= 2` sustains one per cycle with `tl_o_ready_i` held high.
- `tl_o` is held stable while `tl_o.d_valid && !tl_o_ready_i`.
- No combinational path from `tl_o_ready_i` to `tl_i_ready_o` or to any `tl_o` field.

## Test plan
- **Zero response.** Reset, then push opcode AccessAck, size 0, error 0, data 0. Next cycle: `tl_o.d_valid` = 1, rsp_intg = 7'h00, data_intg = 7'h00, `count_o` = 1.
- **Known vectors.** Push AccessAckData, size 2, error 0, data 32'h1 → rsp_intg = 7'h30, data_intg = 7'h19. Push AccessAck, size 0, error 1 → rsp_intg = 7'h07.
- **Back-pressure, Depth = 2.** Hold `tl_o_ready_i` = 0 and push 3 responses → `tl_i_ready_o` drops after the 2nd push and `count_o` = 2. Raise ready → responses pop in order, one per cycle.
- **Simultaneous push/pop at count = 1.** `count_o` stays 1 and the outputs are correct. With `Depth = 3`, 10 back-to-back pushes exercise pointer wrap with no reordering.
- **Pass-through mode.** With `EnableRspIntg` = 0 and `EnableDataIntg` = 0, input d_user = {7'h55, 7'h2A} appears unchanged at `tl_o`.
- **Reset mid-operation.** Assert `rst_ni` low mid-cycle with `count_o` = 2 → `tl_o.d_valid` goes to 0 and `count_o` to 0 before the next clock edge. After release, the first push appears at `tl_o` with no stale data.
